bram_window_reader: RTL and testbench
=====================================

Name: bram_window_reader

Overview:
- Port-B reader for the 9-bank pixel line store filled on port A by the pixel-stream writer.
- For a requested centre row, streams one 3x3 RGB window per column, columns 0..IMG_W-1, to the downstream filter datapath.
- Uses valid/ready backpressure and a 2-entry skid buffer so that the 1-cycle BRAM read latency never drops data.

Parameters:
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- PIX_W, 24, RGB pixel width
- ADDR_W, 8, per-bank address width (depth 256, 214 entries used)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- row_start  in  1  one-cycle request to stream one row
- row_idx  in  10  centre row of the request, sampled with row_start
- row_busy  out  1  high from accepted row_start until row_done
- row_done  out  1  one-cycle pulse after the last window handshake
- enb  out  1  read enable, all 9 banks
- web  out  1  constant 0
- addrb  out  9*ADDR_W  bank k address in bits [8k+7:8k]
- dinb  out  9*PIX_W  constant 0
- doutb  in  9*PIX_W  bank read data; bank k in bits [24k+23:24k]; valid 1 cycle after enb
- win_valid  out  1  window available
- win_ready  in  1  downstream accepts
- win_data  out  9*PIX_W  p(dr,dc), row-major, p(-1,-1) at LSB, p(+1,+1) at MSB
- win_col  out  10  centre column of win_data
- win_last  out  1  win_col == IMG_W-1

Behaviour:
- Storage map (fixed, shared with the writer):
  - Pixel (r,c) lives in bank (r%3)*3 + (c%3), at address c/3.
  - Any 3x3 window therefore hits each bank at most once per cycle.
- Reset values:
  - row_busy, row_done, enb, win_valid, win_last = 0.
  - addrb, win_data, win_col = 0; all counters = 0.
  - web = 0 and dinb = 0 at all times.
- FSM:
  - IDLE: accept row_start when row_idx < IMG_H; latch r%3, (r-1)%3, (r+1)%3 with clamping applied; go to RUN.
  - IDLE: row_start with row_idx >= IMG_H is ignored.
  - RUN: issue one column per cycle when (skid occupancy + in-flight reads) < 2; enb = 1 on issue cycles.
  - RUN: after column IMG_W-1 is issued, go to DRAIN.
  - DRAIN: when the last window handshakes (win_valid && win_ready), pulse row_done next cycle and return to IDLE.
- row_start while row_busy is ignored.
- Column tracking: column index, c%3 and c/3 are held as incremental counters; no divider.
- Neighbour addressing:
  - cc = clamp(c+dc, 0, IMG_W-1); rr = clamp(r+dr, 0, IMG_H-1).
  - Clamped duplicates target the same bank at the same address, so no conflict arises.
- Lane remap: doutb is rotated into window order using the (c%3) and row-phase values issued one cycle earlier, pipelined alongside the read.
- Latency and throughput:
  - row_start accepted in cycle 0; column 0 address issued in cycle 1; win_valid high in cycle 2.
  - With win_ready held at 1: 1 window/cycle, IMG_W+2 cycles from row_start to the row_done pulse.
- Backpressure:
  - While win_valid && !win_ready, win_data, win_col and win_last stay stable.
  - Issue stops once the skid buffer is full.
- Row boundaries:
  - Row 0 uses row 0 for dr = -1.
  - Row IMG_H-1 uses row IMG_H-1 for dr = +1.
- Reset mid-row: returns to IDLE on the next edge; in-flight read data is discarded; no row_done pulse.

Optional Feature:
- Macro: BRAM_WINDOW_ZERO_PAD_EN.
- Defined: out-of-image neighbours are forced to 24'h0 in win_data. Addresses are still generated clamped; the zeroing is a registered mask applied to the lane.
- Undefined: edge-replicate (clamp) behaviour as described above.

Decomposition:
- Shared package (reused by the writer):
  - IMG_W, IMG_H, PIX_W, ADDR_W, NBANK = 9.
  - Function bank_of(row_mod3, col_mod3).
  - Window lane-index constants.
- One sub-module, window_skid_buffer: 2-entry valid/ready skid holding {win_data, win_col, win_last}.

Test Plan:
- Bank preload: pixel(r,c) = {r[7:0], c[9:2], c[1:0]+8'h10}; row_start row_idx = 100, win_ready = 1 -> 640 windows; win_col 0..639; first win_valid 2 cycles after row_start; win_last only at 639; row_done at cycle 642.
- Interior check at row_idx = 100, win_col = 320 -> all 9 lanes equal the preload of rows 99..101 and columns 319..321.
- Edges: row_idx = 0, col 0, clamp build -> p(-1,-1) equals pixel(0,0). Same case with BRAM_WINDOW_ZERO_PAD_EN -> lanes 0,1,2,3,6 are 0.
- Random win_ready (50% duty) at row_idx = 479 -> no lost or duplicated columns; win_data stable while stalled; at most 2 windows buffered.
- row_start pulsed during RUN, then reset asserted at column 200 -> second request ignored; after reset all outputs 0, no row_done; next row_start runs normally.
- row_start with row_idx = 480 -> ignored; row_busy stays 0; enb stays 0.

Source files
------------

// File: rtl/bram_window_reader_pkg.sv
// Shared constants and helpers for the 9-bank pixel line store (writer and reader).
// Bank map: pixel (r,c) -> bank (r%3)*3 + (c%3), address c/3.
package bram_window_reader_pkg;
   localparam int IMG_W  = 640;
   localparam int IMG_H  = 480;
   localparam int PIX_W  = 24;
   localparam int ADDR_W = 8;
   localparam int NBANK  = 9;

   localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
   localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);

   // Window lane order: (dr+1)*3 + (dc+1), p(-1,-1) in lane 0
   localparam int LANE_NW = 0;
   localparam int LANE_N  = 1;
   localparam int LANE_NE = 2;
   localparam int LANE_W  = 3;
   localparam int LANE_C  = 4;
   localparam int LANE_E  = 5;
   localparam int LANE_SW = 6;
   localparam int LANE_S  = 7;
   localparam int LANE_SE = 8;

   function automatic logic [3:0] bank_of(input logic [1:0] row_mod3, input logic [1:0] col_mod3);
      return {2'b00, row_mod3} * 4'd3 + {2'b00, col_mod3};
   endfunction

   function automatic logic [1:0] mod3(input logic [9:0] v);
      logic [9:0] t;
      t = v % 10'd3;
      return t[1:0];
   endfunction
endpackage

// File: rtl/bram_window_skid_buffer.sv
// 2-entry fall-through skid buffer; arriving BRAM data is shown directly when empty.
module window_skid_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid_i,
   input  logic [W-1:0] in_data_i,
   output logic [1:0]   occ_o,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);
   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic         pop;

   assign occ_o       = cnt_q;
   assign out_valid_o = (cnt_q != 2'd0) || in_valid_i;
   assign out_data_o  = (cnt_q != 2'd0) ? e0_q : (in_valid_i ? in_data_i : '0);
   assign pop         = out_valid_o && out_ready_i;

   always_comb begin
      cnt_d = cnt_q;
      e0_d  = e0_q;
      e1_d  = e1_q;
      case (cnt_q)
         2'd0: begin
            if (in_valid_i && !pop) begin
               e0_d  = in_data_i;
               cnt_d = 2'd1;
            end
         end
         2'd1: begin
            if (pop && in_valid_i) begin
               e0_d = in_data_i;
            end else if (pop) begin
               cnt_d = 2'd0;
            end else if (in_valid_i) begin
               e1_d  = in_data_i;
               cnt_d = 2'd2;
            end
         end
         default: begin
            // issue credit keeps a full buffer from seeing a new arrival without a pop
            if (pop) begin
               e0_d = e1_q;
               if (in_valid_i) e1_d = in_data_i;
               else            cnt_d = 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 2'd0;
         e0_q  <= '0;
         e1_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         e0_q  <= e0_d;
         e1_q  <= e1_d;
      end
   end
endmodule

// File: rtl/bram_window_reader.sv
// Port-B reader streaming one 3x3 RGB window per column of a requested centre row.
// BRAM_WINDOW_ZERO_PAD_EN: out-of-image lanes forced to zero instead of edge-replicated.
module bram_window_reader
   import bram_window_reader_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    row_start,
   input  logic [9:0]              row_idx,
   output logic                    row_busy,
   output logic                    row_done,
   output logic                    enb,
   output logic                    web,
   output logic [NBANK*ADDR_W-1:0] addrb,
   output logic [NBANK*PIX_W-1:0]  dinb,
   input  logic [NBANK*PIX_W-1:0]  doutb,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic [NBANK*PIX_W-1:0]  win_data,
   output logic [9:0]              win_col,
   output logic                    win_last
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam int SKID_W = NBANK*PIX_W + 11;

   logic [1:0]                  state_q, state_d;
   logic [9:0]                  col_q, col_d;
   logic [1:0]                  cm_q, cm_d;
   logic [ADDR_W-1:0]           cdiv_q, cdiv_d;
   logic [2:0][1:0]             rm_q, rm_d;
   logic                        done_q, done_d;
   logic                        infl_q;
   logic [NBANK-1:0][3:0]       sel_q, sel_d;
   logic [9:0]                  pcol_q;
   logic                        plast_q;
   logic [2:0][1:0]             ccm;
   logic [2:0][ADDR_W-1:0]      cca, addr_ph;
   logic [NBANK-1:0][PIX_W-1:0] dout_v, lane_v;
   logic [1:0]                  occ;
   logic                        first_c, last_c, accept;
   logic [SKID_W-1:0]           skid_out;

   assign web      = 1'b0;
   assign dinb     = '0;
   assign row_busy = (state_q != S_IDLE);
   assign row_done = done_q;
   assign dout_v   = doutb;

   assign accept  = (state_q == S_IDLE) && row_start && (row_idx < 10'(IMG_H));
   assign enb     = (state_q == S_RUN) && ((occ + {1'b0, infl_q}) < 2'd2);
   assign first_c = (col_q == 10'd0);
   assign last_c  = (col_q == COL_LAST);

   // clamped neighbour columns as (c%3, c/3) pairs for dc = -1, 0, +1
   always_comb begin
      ccm[1] = cm_q;
      cca[1] = cdiv_q;
      ccm[0] = first_c ? 2'd0 : ((cm_q == 2'd0) ? 2'd2 : cm_q - 2'd1);
      cca[0] = (first_c || cm_q != 2'd0) ? cdiv_q - {7'd0, !first_c && cm_q == 2'd0} : cdiv_q - 8'd1;
      ccm[2] = last_c ? cm_q : ((cm_q == 2'd2) ? 2'd0 : cm_q + 2'd1);
      cca[2] = (!last_c && cm_q == 2'd2) ? cdiv_q + 8'd1 : cdiv_q;
   end

   always_comb begin
      addr_ph = '0;
      for (int cb = 0; cb < 3; cb++)
         for (int dc = 0; dc < 3; dc++)
            if (ccm[dc] == 2'(cb)) addr_ph[cb] = cca[dc];
   end

   for (genvar k = 0; k < NBANK; k++) begin : g_addr
      assign addrb[k*ADDR_W +: ADDR_W] = enb ? addr_ph[k % 3] : '0;
   end

`ifdef BRAM_WINDOW_ZERO_PAD_EN
   logic             row_top_q, row_bot_q;
   logic [NBANK-1:0] zm_d, zm_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         row_top_q <= 1'b0;
         row_bot_q <= 1'b0;
         zm_q      <= '0;
      end else begin
         if (accept) begin
            row_top_q <= (row_idx == 10'd0);
            row_bot_q <= (row_idx == ROW_LAST);
         end
         if (enb) zm_q <= zm_d;
      end
   end
`endif

   for (genvar l = 0; l < NBANK; l++) begin : g_lane
      localparam int DR = l / 3;
      localparam int DC = l % 3;
      assign sel_d[l] = bank_of(rm_q[DR], ccm[DC]);
`ifdef BRAM_WINDOW_ZERO_PAD_EN
      assign zm_d[l]   = (DR == 0 && row_top_q) || (DR == 2 && row_bot_q) ||
                         (DC == 0 && first_c) || (DC == 2 && last_c);
      assign lane_v[l] = zm_q[l] ? '0 : dout_v[sel_q[l]];
`else
      assign lane_v[l] = dout_v[sel_q[l]];
`endif
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      cm_d    = cm_q;
      cdiv_d  = cdiv_q;
      rm_d    = rm_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               rm_d[0] = (row_idx == 10'd0) ? 2'd0 : mod3(row_idx - 10'd1);
               rm_d[1] = mod3(row_idx);
               rm_d[2] = (row_idx == ROW_LAST) ? mod3(row_idx) : mod3(row_idx + 10'd1);
               col_d   = '0;
               cm_d    = '0;
               cdiv_d  = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (enb) begin
               if (last_c) begin
                  col_d   = '0;
                  cm_d    = '0;
                  cdiv_d  = '0;
                  state_d = S_DRAIN;
               end else begin
                  col_d  = col_q + 10'd1;
                  cm_d   = (cm_q == 2'd2) ? 2'd0 : cm_q + 2'd1;
                  cdiv_d = (cm_q == 2'd2) ? cdiv_q + 8'd1 : cdiv_q;
               end
            end
         end
         S_DRAIN: begin
            if (win_valid && win_ready && win_last) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         cm_q    <= '0;
         cdiv_q  <= '0;
         rm_q    <= '0;
         done_q  <= 1'b0;
         infl_q  <= 1'b0;
         sel_q   <= '0;
         pcol_q  <= '0;
         plast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         cm_q    <= cm_d;
         cdiv_q  <= cdiv_d;
         rm_q    <= rm_d;
         done_q  <= done_d;
         infl_q  <= enb;
         // lane routing travels with the read so it lines up with doutb next cycle
         if (enb) begin
            sel_q   <= sel_d;
            pcol_q  <= col_q;
            plast_q <= last_c;
         end
      end
   end

   window_skid_buffer #(.W(SKID_W)) u_skid (
      .clk         (clk),
      .reset       (reset),
      .in_valid_i  (infl_q),
      .in_data_i   ({plast_q, pcol_q, lane_v}),
      .occ_o       (occ),
      .out_valid_o (win_valid),
      .out_ready_i (win_ready),
      .out_data_o  (skid_out)
   );

   assign {win_last, win_col, win_data} = skid_out;
endmodule

// File: tb/tb_bram_window_reader.sv
// Scoreboard bench for bram_window_reader: BRAM model, expected-window queue, negedge monitor.
module tb_bram_window_reader;
   import bram_window_reader_pkg::*;

   typedef struct {
      logic [NBANK*PIX_W-1:0] d;
      logic [9:0]             col;
      logic                   last;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    row_start = 1'b0;
   logic [9:0]              row_idx = '0;
   logic                    row_busy, row_done, enb, web;
   logic [NBANK*ADDR_W-1:0] addrb;
   logic [NBANK*PIX_W-1:0]  dinb, doutb, win_data;
   logic                    win_valid, win_ready, win_last;
   logic [9:0]              win_col;

   bram_window_reader dut (
      .clk(clk), .reset(reset), .row_start(row_start), .row_idx(row_idx),
      .row_busy(row_busy), .row_done(row_done), .enb(enb), .web(web),
      .addrb(addrb), .dinb(dinb), .doutb(doutb), .win_valid(win_valid),
      .win_ready(win_ready), .win_data(win_data), .win_col(win_col), .win_last(win_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [PIX_W-1:0]       mem [NBANK][256];
   logic [NBANK*PIX_W-1:0] dout_q = '0;
   always @(posedge clk)
      if (enb)
         for (int k = 0; k < NBANK; k++)
            dout_q[k*PIX_W +: PIX_W] <= mem[k][addrb[k*ADDR_W +: ADDR_W]];
   assign doutb = dout_q;

   int   checks = 0, errors = 0;
   exp_t exp_q[$];
   int   cur_row = 0, start_cyc = 0, first_cyc = 0, done_cyc = 0, done_cnt = 0;
   bit   first_arm = 0, rnd_mode = 0, seen200 = 0;
   int   iss_cnt = 0, hs_cnt = 0, max_out = 0;

   task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, a, e);
      end
   endtask

   function automatic logic [PIX_W-1:0] pixel(input int r, input int c);
      logic [9:0] rv, cv;
      rv = 10'(r);
      cv = 10'(c);
      return {rv[7:0], cv[9:2], 8'h10 + {6'b0, cv[1:0]}};
   endfunction

   function automatic logic [NBANK*PIX_W-1:0] exp_window(input int r, input int c);
      logic [NBANK*PIX_W-1:0] w;
      logic [PIX_W-1:0]       v;
      int rr, cc;
      bit oob;
      w = '0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) begin
            rr  = r + dr;
            cc  = c + dc;
            oob = (rr < 0) || (rr >= IMG_H) || (cc < 0) || (cc >= IMG_W);
            if (rr < 0) rr = 0;
            if (rr >= IMG_H) rr = IMG_H - 1;
            if (cc < 0) cc = 0;
            if (cc >= IMG_W) cc = IMG_W - 1;
            v = pixel(rr, cc);
`ifdef BRAM_WINDOW_ZERO_PAD_EN
            if (oob) v = '0;
`endif
            w[((dr+1)*3 + (dc+1))*PIX_W +: PIX_W] = v;
         end
      return w;
   endfunction

   function automatic logic [PIX_W-1:0] lane(input logic [NBANK*PIX_W-1:0] w, input int l);
      return w[l*PIX_W +: PIX_W];
   endfunction

   // ready: held high, or coin-flipped each cycle during the backpressure run
   initial begin
      win_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 win_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   bit                     stall_q = 0;
   logic [NBANK*PIX_W-1:0] held_d;
   logic [9:0]             held_c;
   logic                   held_l;

   always @(negedge clk) begin
      if (reset) begin
         stall_q = 0;
         iss_cnt = 0;
         hs_cnt  = 0;
      end else begin
         if (stall_q)
            chk("stall_hold", {win_valid, win_last, win_col, win_data}, {1'b1, held_l, held_c, held_d});
         if (win_valid && first_arm) begin
            first_cyc = cyc;
            first_arm = 0;
         end
         if (row_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (enb) iss_cnt++;
         if (win_valid && win_ready) begin
            hs_cnt++;
            if (win_col == 10'd200) seen200 = 1;
            if (exp_q.size() == 0) begin
               chk("unexpected_win", {win_col, 1'b1}, {win_col, 1'b0});
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("win_data", win_data, e.d);
               chk("win_col", win_col, e.col);
               chk("win_last", win_last, e.last);
            end
            if (cur_row == 100 && win_col == 10'd320) begin
               chk("int_nw", lane(win_data, LANE_NW), 24'h634F13);
               chk("int_c",  lane(win_data, LANE_C),  24'h645010);
               chk("int_se", lane(win_data, LANE_SE), 24'h655011);
            end
            if (cur_row == 0 && win_col == 10'd0) begin
               chk("top_c", lane(win_data, LANE_C), 24'h000010);
`ifdef BRAM_WINDOW_ZERO_PAD_EN
               chk("top_pad", {lane(win_data, LANE_NW), lane(win_data, LANE_N), lane(win_data, LANE_NE),
                               lane(win_data, LANE_W), lane(win_data, LANE_SW)}, 120'h0);
`else
               chk("top_nw", lane(win_data, LANE_NW), 24'h000010);
               chk("top_ne", lane(win_data, LANE_NE), 24'h000011);
               chk("top_sw", lane(win_data, LANE_SW), 24'h010010);
`endif
            end
            if (cur_row == 479 && win_col == 10'd0) begin
`ifdef BRAM_WINDOW_ZERO_PAD_EN
               chk("bot_se", lane(win_data, LANE_SE), 24'h000000);
`else
               chk("bot_se", lane(win_data, LANE_SE), 24'hDF0011);
`endif
            end
         end
         if (iss_cnt - hs_cnt > max_out) max_out = iss_cnt - hs_cnt;
         stall_q = win_valid && !win_ready;
         held_d  = win_data;
         held_c  = win_col;
         held_l  = win_last;
      end
   end

   task automatic preload(input int r);
      int rows[3];
      rows[0] = (r == 0) ? 0 : r - 1;
      rows[1] = r;
      rows[2] = (r == IMG_H - 1) ? r : r + 1;
      for (int i = 0; i < 3; i++)
         for (int c = 0; c < IMG_W; c++)
            mem[(rows[i] % 3)*3 + (c % 3)][c / 3] = pixel(rows[i], c);
   endtask

   task automatic start_row(input int r);
      exp_t e;
      cur_row = r;
      for (int c = 0; c < IMG_W; c++) begin
         e.d    = exp_window(r, c);
         e.col  = 10'(c);
         e.last = (c == IMG_W - 1);
         exp_q.push_back(e);
      end
      first_arm = 1;
      @(posedge clk);
      #1 row_idx = 10'(r);
      row_start = 1'b1;
      start_cyc = cyc;
      @(posedge clk);
      #1 row_start = 1'b0;
   endtask

   task automatic run_row(input int r, input bit rnd);
      int d0, n;
      d0 = done_cnt;
      start_row(r);
      n = 0;
      while (done_cnt == d0 && n < 4000) begin
         @(negedge clk);
         #1 n++;
      end
      chk("row_done_seen", done_cnt - d0, 1);
      chk("first_valid_lat", first_cyc - start_cyc, 2);
      if (!rnd) chk("row_done_lat", done_cyc - start_cyc, IMG_W + 2);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_busy"},  row_busy, 0);
      chk({nm, "_done"},  row_done, 0);
      chk({nm, "_enb"},   enb, 0);
      chk({nm, "_web"},   web, 0);
      chk({nm, "_addrb"}, addrb, 0);
      chk({nm, "_dinb"},  dinb, 0);
      chk({nm, "_valid"}, win_valid, 0);
      chk({nm, "_data"},  win_data, 0);
      chk({nm, "_col"},   win_col, 0);
      chk({nm, "_last"},  win_last, 0);
   endtask

   initial begin
      int n;
      bit act;
      repeat (3) @(posedge clk);
      #1 check_zero("rst");
      reset = 1'b0;

      preload(100);
      run_row(100, 0);
      preload(0);
      run_row(0, 0);
      preload(479);
      rnd_mode = 1;
      run_row(479, 1);
      rnd_mode = 0;
      chk("max_buffered", 1'(max_out <= 2), 1'b1);

      // second request during RUN, then reset mid-row
      preload(100);
      seen200 = 0;
      start_row(100);
      repeat (50) @(posedge clk);
      #1 row_idx = 10'd5;
      row_start = 1'b1;
      @(posedge clk);
      #1 row_start = 1'b0;
      chk("busy_in_run", row_busy, 1);
      n = 0;
      while (!seen200 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_col200", seen200, 1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 check_zero("midrst");
      exp_q.delete();
      first_arm = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1 check_zero("postrst");
      chk("no_done_on_reset", done_cnt, 3);

      preload(1);
      run_row(1, 0);

      // out-of-range row is ignored
      @(posedge clk);
      #1 row_idx = 10'd480;
      row_start = 1'b1;
      @(posedge clk);
      #1 row_start = 1'b0;
      act = 0;
      repeat (10) begin
         @(negedge clk);
         if (row_busy || enb || win_valid) act = 1;
      end
      chk("oor_ignored", act, 0);
      chk("done_total", done_cnt, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
